// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-request ALU execution unit with a valid/ready handshake
// on both sides. Shifts run one bit per cycle; all other ops take one cycle.
// Optional feature macro: ALU_OVERFLOW_EN. When it is defined, signed overflow
// is detected for add/sub. When it is undefined, the overflow port is tied to 0.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_function,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpXnor = 4'b0100;
  localparam logic [3:0] OpShl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpShr  = 4'b1000;
  localparam logic [3:0] OpCpl  = 4'b1001;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               illegal_q, illegal_d;
  logic [4:0]         count_q, count_d;
  logic               shiftLeft_q, shiftLeft_d;

  logic               accept;
  logic               isShift;
  logic [4:0]         shamt;
  logic [WIDTH-1:0]   addResult;
  logic [WIDTH-1:0]   subResult;
  logic [WIDTH-1:0]   aluResult;
  logic               aluIllegal;

  assign accept    = in_valid & in_ready;
  assign shamt     = operand_b[4:0];
  assign isShift   = (alu_function == OpShl) || (alu_function == OpShr);
  assign addResult = operand_a + operand_b;
  assign subResult = operand_a - operand_b;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;
  // zero only means something once the final result is registered in DONE
  assign zero      = (state_q == DONE) && (result_q == '0);

  // Single-cycle operations; unsupported codes produce 0 and flag illegal
  always_comb begin
    aluResult  = '0;
    aluIllegal = 1'b0;
    case (alu_function)
      OpAnd:   aluResult = operand_a & operand_b;
      OpOr:    aluResult = operand_a | operand_b;
      OpAdd:   aluResult = addResult;
      OpXor:   aluResult = operand_a ^ operand_b;
      OpXnor:  aluResult = ~(operand_a ^ operand_b);
      OpSub:   aluResult = subResult;
      OpSlt:   aluResult[0] = ($signed(operand_a) < $signed(operand_b));
      OpCpl:   aluResult = ~operand_a;
      OpShl,
      OpShr:   aluResult = operand_a;
      default: aluIllegal = 1'b1;
    endcase
  end

  // Next-state logic: shifts iterate in SHIFT until the count drains, others go straight to DONE
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    count_d     = count_q;
    shiftLeft_d = shiftLeft_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          result_d    = aluResult;
          illegal_d   = aluIllegal;
          shiftLeft_d = (alu_function == OpShl);
          if (isShift && (shamt != 5'd0)) begin
            count_d = shamt;
            state_d = SHIFT;
          end else begin
            count_d = 5'd0;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        result_d = shiftLeft_q ? (result_q << 1) : (result_q >> 1);
        count_d  = count_q - 5'd1;
        if (count_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      count_q     <= 5'd0;
      shiftLeft_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      count_q     <= count_d;
      shiftLeft_q <= shiftLeft_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic overflow_q, overflow_d;
  logic signA, signB;

  assign signA    = operand_a[WIDTH-1];
  assign signB    = operand_b[WIDTH-1];
  assign overflow = overflow_q;

  // Signed overflow is captured with the request and held until the result is consumed
  always_comb begin
    overflow_d = overflow_q;
    if (accept) begin
      case (alu_function)
        OpAdd:   overflow_d = (signA == signB) && (addResult[WIDTH-1] != signA);
        OpSub:   overflow_d = (signA != signB) && (subResult[WIDTH-1] != signA);
        default: overflow_d = 1'b0;
      endcase
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit. Stimulus pushes the
// expected response into a scoreboard queue; a negedge monitor pops and
// compares each result as the DUT hands it over.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

`ifdef ALU_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpXnor = 4'b0100;
  localparam logic [3:0] OpShl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpShr  = 4'b1000;
  localparam logic [3:0] OpCpl  = 4'b1001;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        illegal;
    logic        overflow;
    int          latency;
    int          acceptCycle;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_function;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             overflow;

  exp_t sbQ[$];
  exp_t monItem;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   riseCycle = 0;
  bit   prevValid = 1'b0;
  int   lastAccept = 0;
  bit   sawValid;
  int   gapStart;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_function (alu_function),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .illegal      (illegal),
    .overflow     (overflow)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure accept-to-valid latency
  always @(posedge clk) begin
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request, waits (bounded) for the handshake and optionally records the expected response
  task automatic applyStimulus(input string name, input logic [3:0] fn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expResult,
                               input logic expIllegal, input logic expOverflow,
                               input int expLatency, input bit expectResult);
    int   waited;
    exp_t e;
    alu_function = fn;
    operand_a    = a;
    operand_b    = b;
    in_valid     = 1'b1;
    waited       = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_acceptTimeout: in_ready stayed 0 for %0d cycles, expected 1", name, waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lastAccept   = cycle;
    in_valid     = 1'b0;
    alu_function = 4'b1111;
    operand_a    = 32'hA5A5_5A5A;
    operand_b    = 32'h0000_001F;
    if (expectResult) begin
      e.name        = name;
      e.result      = expResult;
      e.illegal     = expIllegal;
      e.overflow    = expOverflow & OvfEn;
      e.latency     = expLatency;
      e.acceptCycle = lastAccept;
      sbQ.push_back(e);
    end
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic waitDrain(input string name);
    int waited;
    waited = 0;
    while (sbQ.size() > 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (sbQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drainTimeout: %0d results outstanding, expected 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  // Monitor: records when out_valid rises and checks each result as it is consumed
  always @(negedge clk) begin
    if (rst_n && out_valid && !prevValid) begin
      riseCycle = cycle;
    end
    prevValid = out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResult: got result 0x%08h with empty scoreboard, expected none", result);
      end else begin
        monItem = sbQ.pop_front();
        checkOutput({monItem.name, "_result"}, result, monItem.result);
        checkOutput({monItem.name, "_zero"}, {31'd0, zero}, {31'd0, (monItem.result == 32'd0)});
        checkOutput({monItem.name, "_illegal"}, {31'd0, illegal}, {31'd0, monItem.illegal});
        checkOutput({monItem.name, "_overflow"}, {31'd0, overflow}, {31'd0, monItem.overflow});
        checkOutput({monItem.name, "_latency"}, riseCycle - monItem.acceptCycle + 1, monItem.latency);
      end
    end
  end

  // Directed test sequence
  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    alu_function = 4'd0;
    operand_a    = '0;
    operand_b    = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_inReady", {31'd0, in_ready}, 32'd1);

    // Arithmetic, logic and compare ops
    applyStimulus("addOvf",  OpAdd,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b1);
    applyStimulus("subZero", OpSub,  32'd5,         32'd5,         32'h0000_0000, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("subOvf",  OpSub,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b1);
    applyStimulus("sltNeg",  OpSlt,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("sltPos",  OpSlt,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("and",     OpAnd,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("or",      OpOr,   32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("xor",     OpXor,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("xnor",    OpXnor, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("cpl",     OpCpl,  32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("badA",    4'b1010, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1);

    // Shifts: latency is 1 + shamt, only operand_b[4:0] counts
    applyStimulus("shl31",   OpShl,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32, 1'b1);
    applyStimulus("shr0",    OpShr,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("shr4",    OpShr,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 5, 1'b1);
    applyStimulus("shl3",    OpShl,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b0, 1'b0, 4, 1'b1);
    waitDrain("basic");

    // Illegal code held in DONE while the consumer stalls
    out_ready = 1'b0;
    applyStimulus("bad1111", 4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_outValid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_inReady", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_result", result, 32'd0);
      checkOutput("stall_illegal", {31'd0, illegal}, 32'd1);
      checkOutput("stall_zero", {31'd0, zero}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    waitDrain("stall");

    // Reset in the middle of a shift discards the operation
    applyStimulus("shlAbort", OpShl, 32'h0000_0001, 32'h0000_000A, 32'h0000_0400, 1'b0, 1'b0, 11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midRst_outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("midRst_result", result, 32'd0);
    checkOutput("midRst_inReady", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRst_inReady", {31'd0, in_ready}, 32'd1);
    sawValid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("postRst_noValid", {31'd0, sawValid}, 32'd0);
    applyStimulus("addAfterRst", OpAdd, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b1);
    waitDrain("reset");

    // Back-to-back requests with the consumer always ready
    applyStimulus("b2bAdd", OpAdd, 32'd1,  32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b1);
    gapStart = lastAccept;
    applyStimulus("b2bSub", OpSub, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("b2bGap1", {31'd0, (lastAccept - gapStart) >= 2}, 32'd1);
    gapStart = lastAccept;
    applyStimulus("b2bXor", OpXor, 32'd3,  32'd3, 32'd0, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("b2bGap2", {31'd0, (lastAccept - gapStart) >= 2}, 32'd1);
    gapStart = lastAccept;
    applyStimulus("b2bOr",  OpOr,  32'd1,  32'd2, 32'd3, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("b2bGap3", {31'd0, (lastAccept - gapStart) >= 2}, 32'd1);
    waitDrain("b2b");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
